// File: rtl/if_id_stage_if.sv
// Fetch-stage bus: hazard/branch controls and instruction memory in, fetch PC and IF/ID register out.
// Handshake: none; controls are level-sensitive and sampled on the rising edge of clk.
interface if_id_stage_if;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic [31:0] instr_in;
    logic [31:0] pc_out;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc_plus4;
    logic        ifid_valid;
    logic [31:0] fetch_count;

    modport master (
        output stall, branch_taken, branch_target, jump, jump_target, instr_in,
        input  pc_out, ifid_instr, ifid_pc_plus4, ifid_valid, fetch_count
    );

    modport slave (
        input  stall, branch_taken, branch_target, jump, jump_target, instr_in,
        output pc_out, ifid_instr, ifid_pc_plus4, ifid_valid, fetch_count
    );
endinterface

// File: rtl/if_id_stage.sv
// Instruction fetch PC register plus IF/ID pipeline register.
// Reset beats redirect, redirect beats stall, and an idle cycle fetches sequentially.
module if_id_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         reset,
    if_id_stage_if.slave bus
);
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic        valid_q, valid_d;
    logic [31:0] count_q, count_d;

    logic [31:0] pc_plus4;
    logic        redirect;
    logic [31:0] redirect_addr;

    assign pc_plus4      = pc_q + 32'd4;
    assign redirect      = bus.branch_taken | bus.jump;
    // Branch wins over jump; targets are word-aligned before use.
    assign redirect_addr = bus.branch_taken ? {bus.branch_target[31:2], 2'b00}
                                            : {bus.jump_target[31:2], 2'b00};

    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        count_d = count_q;
        if (redirect) begin
            // Flush the wrong-path fetch; pc+4 is left as-is.
            pc_d    = redirect_addr;
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end else if (!bus.stall) begin
            pc_d    = pc_plus4;
            instr_d = bus.instr_in;
            pc4_d   = pc_plus4;
            valid_d = 1'b1;
            count_d = count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            pc4_q   <= 32'h0000_0000;
            valid_q <= 1'b0;
            count_q <= 32'h0000_0000;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

    assign bus.pc_out        = pc_q;
    assign bus.ifid_instr    = instr_q;
    assign bus.ifid_pc_plus4 = pc4_q;
    assign bus.ifid_valid    = valid_q;
    assign bus.fetch_count   = count_q;
endmodule

// File: tb/tb_if_id_stage.sv
// Directed bench for if_id_stage: a default instance and one with RESET_PC near the top of memory.
module tb_if_id_stage;
    logic        clk;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic [31:0] instr_in;

    int checks;
    int passed;

    if_id_stage_if bus_a ();
    if_id_stage_if bus_b ();

    assign bus_a.stall         = stall;
    assign bus_a.branch_taken  = branch_taken;
    assign bus_a.branch_target = branch_target;
    assign bus_a.jump          = jump;
    assign bus_a.jump_target   = jump_target;
    assign bus_a.instr_in      = instr_in;
    assign bus_b.stall         = stall;
    assign bus_b.branch_taken  = branch_taken;
    assign bus_b.branch_target = branch_target;
    assign bus_b.jump          = jump;
    assign bus_b.jump_target   = jump_target;
    assign bus_b.instr_in      = instr_in;

    if_id_stage dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    if_id_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    // clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 32'h0;
        jump          = 1'b0;
        jump_target   = 32'h0;
    endtask

    task automatic test_reset();
        reset = 1'b1; stall = 1'b1; jump = 1'b1; jump_target = 32'h0000_0500;
        instr_in = 32'hCAFE_F00D;
        step();
        step();
        checks++; if (bus_a.pc_out !== 32'h0) $display("FAIL reset_pc: got %h expected %h", bus_a.pc_out, 32'h0); else passed++;
        checks++; if (bus_a.ifid_instr !== 32'h0) $display("FAIL reset_instr: got %h expected %h", bus_a.ifid_instr, 32'h0); else passed++;
        checks++; if (bus_a.ifid_pc_plus4 !== 32'h0) $display("FAIL reset_pc4: got %h expected %h", bus_a.ifid_pc_plus4, 32'h0); else passed++;
        checks++; if (bus_a.ifid_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", bus_a.ifid_valid); else passed++;
        checks++; if (bus_a.fetch_count !== 32'h0) $display("FAIL reset_count: got %h expected %h", bus_a.fetch_count, 32'h0); else passed++;
        idle_inputs();
        reset = 1'b0;
    endtask

    task automatic test_free_run();
        logic [31:0] exp_pc[3];
        exp_pc[0] = 32'h4; exp_pc[1] = 32'h8; exp_pc[2] = 32'hC;
        instr_in = 32'h2008_0005;
        checks++; if (bus_a.pc_out !== 32'h0) $display("FAIL run_pc0: got %h expected %h", bus_a.pc_out, 32'h0); else passed++;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (bus_a.pc_out !== exp_pc[i]) $display("FAIL run_pc[%0d]: got %h expected %h", i, bus_a.pc_out, exp_pc[i]); else passed++;
            checks++; if (bus_a.ifid_pc_plus4 !== exp_pc[i]) $display("FAIL run_pc4[%0d]: got %h expected %h", i, bus_a.ifid_pc_plus4, exp_pc[i]); else passed++;
            if (i == 0) begin
                checks++; if (bus_a.ifid_instr !== 32'h2008_0005) $display("FAIL run_instr: got %h expected %h", bus_a.ifid_instr, 32'h2008_0005); else passed++;
                checks++; if (bus_a.ifid_valid !== 1'b1) $display("FAIL run_valid: got %b expected 1", bus_a.ifid_valid); else passed++;
            end
        end
        checks++; if (bus_a.fetch_count !== 32'd3) $display("FAIL run_count: got %0d expected 3", bus_a.fetch_count); else passed++;
    endtask

    task automatic test_stall();
        reset = 1'b1;
        step();
        reset = 1'b0;
        instr_in = 32'hAAAA_0001;
        step();
        instr_in = 32'hAAAA_0002;
        step();
        // pc_out now 0x8, IF/ID holds 0xAAAA0002 / 0x8, count 2
        stall = 1'b1;
        instr_in = 32'hDEAD_BEEF;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++; if (bus_a.pc_out !== 32'h8) $display("FAIL stall_pc[%0d]: got %h expected %h", i, bus_a.pc_out, 32'h8); else passed++;
            checks++; if (bus_a.ifid_instr !== 32'hAAAA_0002) $display("FAIL stall_instr[%0d]: got %h expected %h", i, bus_a.ifid_instr, 32'hAAAA_0002); else passed++;
            checks++; if (bus_a.ifid_pc_plus4 !== 32'h8) $display("FAIL stall_pc4[%0d]: got %h expected %h", i, bus_a.ifid_pc_plus4, 32'h8); else passed++;
            checks++; if (bus_a.fetch_count !== 32'd2) $display("FAIL stall_count[%0d]: got %0d expected 2", i, bus_a.fetch_count); else passed++;
        end
        stall = 1'b0;
        instr_in = 32'h1111_1111;
        step();
        checks++; if (bus_a.pc_out !== 32'hC) $display("FAIL release_pc: got %h expected %h", bus_a.pc_out, 32'hC); else passed++;
        checks++; if (bus_a.ifid_instr !== 32'h1111_1111) $display("FAIL release_instr: got %h expected %h", bus_a.ifid_instr, 32'h1111_1111); else passed++;
        checks++; if (bus_a.fetch_count !== 32'd3) $display("FAIL release_count: got %0d expected 3", bus_a.fetch_count); else passed++;
    endtask

    task automatic test_branch();
        instr_in = 32'h2222_2222;
        step();
        checks++; if (bus_a.pc_out !== 32'h10) $display("FAIL pre_branch_pc: got %h expected %h", bus_a.pc_out, 32'h10); else passed++;
        branch_taken = 1'b1; branch_target = 32'h43; instr_in = 32'h3333_3333;
        step();
        checks++; if (bus_a.pc_out !== 32'h40) $display("FAIL branch_pc: got %h expected %h", bus_a.pc_out, 32'h40); else passed++;
        checks++; if (bus_a.ifid_valid !== 1'b0) $display("FAIL branch_valid: got %b expected 0", bus_a.ifid_valid); else passed++;
        checks++; if (bus_a.ifid_instr !== 32'h0) $display("FAIL branch_instr: got %h expected %h", bus_a.ifid_instr, 32'h0); else passed++;
        checks++; if (bus_a.ifid_pc_plus4 !== 32'h10) $display("FAIL branch_pc4: got %h expected %h", bus_a.ifid_pc_plus4, 32'h10); else passed++;
        checks++; if (bus_a.fetch_count !== 32'd4) $display("FAIL branch_count: got %0d expected 4", bus_a.fetch_count); else passed++;
        idle_inputs();
        instr_in = 32'h4444_4444;
        step();
        checks++; if (bus_a.pc_out !== 32'h44) $display("FAIL after_branch_pc: got %h expected %h", bus_a.pc_out, 32'h44); else passed++;
        checks++; if (bus_a.ifid_instr !== 32'h4444_4444) $display("FAIL after_branch_instr: got %h expected %h", bus_a.ifid_instr, 32'h4444_4444); else passed++;
        checks++; if (bus_a.ifid_pc_plus4 !== 32'h44) $display("FAIL after_branch_pc4: got %h expected %h", bus_a.ifid_pc_plus4, 32'h44); else passed++;
        checks++; if (bus_a.ifid_valid !== 1'b1) $display("FAIL after_branch_valid: got %b expected 1", bus_a.ifid_valid); else passed++;
    endtask

    task automatic test_redirect_priority();
        stall = 1'b1; jump = 1'b1; jump_target = 32'h100;
        step();
        checks++; if (bus_a.pc_out !== 32'h100) $display("FAIL jump_stall_pc: got %h expected %h", bus_a.pc_out, 32'h100); else passed++;
        checks++; if (bus_a.ifid_valid !== 1'b0) $display("FAIL jump_stall_valid: got %b expected 0", bus_a.ifid_valid); else passed++;
        checks++; if (bus_a.ifid_pc_plus4 !== 32'h44) $display("FAIL jump_stall_pc4: got %h expected %h", bus_a.ifid_pc_plus4, 32'h44); else passed++;
        stall = 1'b0; branch_taken = 1'b1; branch_target = 32'h200; jump_target = 32'h300;
        step();
        checks++; if (bus_a.pc_out !== 32'h200) $display("FAIL branch_over_jump_pc: got %h expected %h", bus_a.pc_out, 32'h200); else passed++;
        branch_taken = 1'b0; jump_target = 32'h307;
        step();
        checks++; if (bus_a.pc_out !== 32'h304) $display("FAIL jump_align_pc: got %h expected %h", bus_a.pc_out, 32'h304); else passed++;
        checks++; if (bus_a.fetch_count !== 32'd5) $display("FAIL redirect_count: got %0d expected 5", bus_a.fetch_count); else passed++;
        idle_inputs();
    endtask

    task automatic test_reset_override();
        stall = 1'b1; jump = 1'b1; jump_target = 32'h800; reset = 1'b1;
        step();
        checks++; if (bus_a.pc_out !== 32'h0) $display("FAIL rst_ovr_pc: got %h expected %h", bus_a.pc_out, 32'h0); else passed++;
        checks++; if (bus_a.ifid_valid !== 1'b0) $display("FAIL rst_ovr_valid: got %b expected 0", bus_a.ifid_valid); else passed++;
        checks++; if (bus_a.fetch_count !== 32'h0) $display("FAIL rst_ovr_count: got %0d expected 0", bus_a.fetch_count); else passed++;
        reset = 1'b0;
        idle_inputs();
        instr_in = 32'h5555_5555;
        step();
        checks++; if (bus_a.ifid_pc_plus4 !== 32'h4) $display("FAIL rst_first_pc4: got %h expected %h", bus_a.ifid_pc_plus4, 32'h4); else passed++;
        checks++; if (bus_a.pc_out !== 32'h4) $display("FAIL rst_first_pc: got %h expected %h", bus_a.pc_out, 32'h4); else passed++;
    endtask

    task automatic test_glitch();
        // instr_in wiggles mid-cycle but is settled before the edge
        instr_in = 32'h6666_6666;
        #2 instr_in = 32'h7777_7777;
        #2 instr_in = 32'h8888_8888;
        step();
        checks++; if (bus_a.ifid_instr !== 32'h8888_8888) $display("FAIL glitch_instr: got %h expected %h", bus_a.ifid_instr, 32'h8888_8888); else passed++;
    endtask

    task automatic test_wrap();
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++; if (bus_b.pc_out !== 32'hFFFF_FFF8) $display("FAIL wrap_pc0: got %h expected %h", bus_b.pc_out, 32'hFFFF_FFF8); else passed++;
        instr_in = 32'h9999_0001;
        step();
        checks++; if (bus_b.pc_out !== 32'hFFFF_FFFC) $display("FAIL wrap_pc1: got %h expected %h", bus_b.pc_out, 32'hFFFF_FFFC); else passed++;
        checks++; if (bus_b.ifid_pc_plus4 !== 32'hFFFF_FFFC) $display("FAIL wrap_pc4_1: got %h expected %h", bus_b.ifid_pc_plus4, 32'hFFFF_FFFC); else passed++;
        instr_in = 32'h9999_0002;
        step();
        checks++; if (bus_b.pc_out !== 32'h0) $display("FAIL wrap_pc2: got %h expected %h", bus_b.pc_out, 32'h0); else passed++;
        checks++; if (bus_b.ifid_pc_plus4 !== 32'h0) $display("FAIL wrap_pc4_2: got %h expected %h", bus_b.ifid_pc_plus4, 32'h0); else passed++;
        checks++; if (bus_b.ifid_instr !== 32'h9999_0002) $display("FAIL wrap_instr: got %h expected %h", bus_b.ifid_instr, 32'h9999_0002); else passed++;
    endtask

    initial begin
        checks = 0;
        passed = 0;
        idle_inputs();
        reset = 1'b1;
        instr_in = 32'h0;
        test_reset();
        test_free_run();
        test_stall();
        test_branch();
        test_redirect_priority();
        test_reset_override();
        test_glitch();
        test_wrap();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/if_id_stage.md
IF_ID_STAGE -- requirements
Module: if_id_stage

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter: NOP_INSTR, 32'h0000_0000, instruction word inserted as a bubble (sll $0,$0,0).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high; sampled on rising edge of clk.
REQ-005 stall  input  1  hazard unit request to hold PC and IF/ID contents.
REQ-006 branch_taken  input  1  branch resolved taken in ID this cycle.
REQ-007 branch_target  input  32  branch destination address.
REQ-008 jump  input  1  jump (J/JAL/JR) resolved in ID this cycle.
REQ-009 jump_target  input  32  jump destination address.
REQ-010 instr_in  input  32  instruction word returned by instruction memory for pc_out, valid same cycle.
REQ-011 pc_out  output  32  current fetch address driven to instruction memory.
REQ-012 ifid_instr  output  32  registered instruction for ID stage.
REQ-013 ifid_pc_plus4  output  32  registered fetch address + 4 for ID stage.
REQ-014 ifid_valid  output  1  1 = ifid_instr is a real fetched instruction, 0 = bubble.
REQ-015 fetch_count  output  32  count of instructions accepted into IF/ID.

Function
REQ-016 pc_out SHALL be a 32-bit register; pc_plus4 = pc_out + 4, modulo 2^32 (wrap 0xFFFFFFFC -> 0x00000000).
REQ-017 Redirect = branch_taken | jump; redirect address SHALL be branch_target when branch_taken=1, else jump_target (branch has priority when both asserted).
REQ-018 Redirect address bits [1:0] SHALL be forced to 2'b00 before loading into PC.
REQ-019 Next PC priority per cycle: reset > redirect > stall (hold) > pc_plus4.
REQ-020 Redirect SHALL override stall: PC loads redirect address even when stall=1.
REQ-021 On redirect, IF/ID SHALL load ifid_instr=NOP_INSTR, ifid_valid=0, ifid_pc_plus4 unchanged (flush of the wrong-path fetch), regardless of stall.
REQ-022 On stall without redirect, ifid_instr, ifid_pc_plus4, ifid_valid and PC SHALL all hold their values.
REQ-023 With neither stall nor redirect, IF/ID SHALL load instr_in, pc_plus4, valid=1 on the rising edge.
REQ-024 fetch_count SHALL increment by 1 exactly on edges where REQ-023 applies; wraps 0xFFFFFFFF -> 0.
REQ-025 Fetch-to-ID latency: instruction at pc_out in cycle N appears on ifid_instr in cycle N+1 when not stalled.
REQ-026 Block contains no combinational path from stall/branch/jump inputs to pc_out; pc_out changes only at a clock edge.
REQ-027 instr_in SHALL be sampled only at the clock edge; glitches between edges have no effect.

Reset
REQ-028 On a rising edge with reset=1: pc_out=RESET_PC, ifid_instr=NOP_INSTR, ifid_pc_plus4=0, ifid_valid=0, fetch_count=0.
REQ-029 Reset SHALL override stall, branch_taken and jump in the same cycle.
REQ-030 Reset asserted mid-stall or mid-redirect SHALL discard the pending operation; first edge after reset deasserts fetches from RESET_PC.
REQ-031 Outputs are undefined before the first reset edge; bench SHALL apply reset at least 1 cycle.

Verification
REQ-032 Reset then 3 free-run cycles, instr_in=0x20080005 -> pc_out 0x0,0x4,0x8,0xC; ifid_instr=0x20080005, ifid_pc_plus4=0x4 after cycle 1, fetch_count=3.
REQ-033 pc_out=0x8, stall=1 for 2 cycles -> pc_out stays 0x8, IF/ID unchanged, fetch_count unchanged; releases to 0xC.
REQ-034 pc_out=0x10, branch_taken=1, branch_target=0x43 -> next pc_out=0x40, ifid_valid=0, ifid_instr=0x00000000.
REQ-035 stall=1, jump=1, jump_target=0x100 same cycle -> pc_out=0x100, ifid_valid=0; branch_taken=1 (target 0x200) with jump=1 (target 0x300) -> pc_out=0x200.
REQ-036 RESET_PC=0xFFFFFFF8, free run -> pc_out 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000; ifid_pc_plus4=0x0 for fetch at 0xFFFFFFFC.
REQ-037 reset=1 while stall=1 and jump=1 -> pc_out=RESET_PC, ifid_valid=0, fetch_count=0 next edge.
